// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix multiplier front end: the skewer FSM
// states and the helpers that size the skewer from the bus geometry.
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } skew_state_t;

  // Number of matrix elements carried by one row/column word, which is also
  // the matrix dimension and the number of pusher lanes.
  function automatic int dim_f(input int bus, input int data);
    return bus / data;
  endfunction

  // The counter spans both the issue phase (DIM cycles) and the drain phase
  // (DIM cycles), so it must be able to hold 2*DIM-1 without wrapping.
  function automatic int cnt_width_f(input int dim);
    return (dim < 1) ? 1 : $clog2(2 * dim);
  endfunction

endpackage

// File: rtl/operand_skewer.sv
// Operand skewer: latches a DIM x DIM operand matrix on start and feeds
// word k to pusher lane k for a single cycle, k cycles after lane 0, so the
// elements enter the systolic array on a diagonal. After the issue phase it
// waits DIM more cycles for the byte-serialising pushers to drain, then
// pulses done_o.
module operand_skewer
  import matmul_pkg::*;
#(
  parameter int BUS_WIDTH  = 32,
  parameter int DATA_WIDTH = 8
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   start_i,
  input  logic [dim_f(BUS_WIDTH,DATA_WIDTH)*BUS_WIDTH-1:0] mat_i,
  output logic [dim_f(BUS_WIDTH,DATA_WIDTH)*BUS_WIDTH-1:0] lane_o,
  output logic                                   ready_o,
  output logic                                   busy_o,
  output logic                                   done_o
);

  localparam int DIM = dim_f(BUS_WIDTH, DATA_WIDTH);
  localparam int CW  = cnt_width_f(DIM);
  localparam int MW  = DIM * BUS_WIDTH;

  localparam logic [CW-1:0] LAST_ISSUE = CW'(DIM - 1);
  localparam logic [CW-1:0] LAST_DRAIN = CW'(2 * DIM - 1);

  // A word that does not split into whole elements cannot feed the pushers.
  if (BUS_WIDTH % DATA_WIDTH != 0) begin : g_width_check
    $error("operand_skewer: BUS_WIDTH must be a multiple of DATA_WIDTH");
  end

  skew_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [MW-1:0] latch_q, latch_d;
  logic [MW-1:0] lane_q, lane_d;

  // State, counter, operand latch and lane registers; reset abandons any
  // sequence in flight and clears the lanes at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      latch_q <= '0;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      latch_q <= latch_d;
      lane_q  <= lane_d;
    end
  end

  // Next-state logic: start is honoured only from IDLE, which is also what
  // makes a start during busy leave the latch untouched. The counter is
  // cleared on every IDLE entry and simply counts through ISSUE and DRAIN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch_d = latch_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = ISSUE;
          cnt_d   = '0;
          latch_d = mat_i;
        end
      end
      ISSUE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ISSUE) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_q == LAST_DRAIN) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Lane mux: evaluated on the upcoming state so that the registered lane
  // word appears the cycle right after the start edge. Only the lane whose
  // index matches the counter carries data; every other lane is forced to
  // zero, so no lane is ever held nonzero long enough to re-trigger a pusher.
  for (genvar k = 0; k < DIM; k++) begin : g_lane
    assign lane_d[k*BUS_WIDTH +: BUS_WIDTH] =
      ((state_d == ISSUE) && (cnt_d == CW'(k))) ? latch_d[k*BUS_WIDTH +: BUS_WIDTH]
                                                : '0;
  end

  // Status flags come straight from the registered state and counter.
  always_comb begin
    busy_o  = (state_q != IDLE);
    ready_o = (state_q == IDLE);
    done_o  = (state_q == DRAIN) && (cnt_q == LAST_DRAIN);
    lane_o  = lane_q;
  end

endmodule

// File: tb/tb_operand_skewer.sv
// Testbench for operand_skewer (BUS_WIDTH=32, DATA_WIDTH=8, DIM=4).
// The reference model describes a sequence purely by its position relative
// to the accepting start edge: lane k carries word k at position k, done
// pulses at position 2*DIM-1, and the block is busy for 2*DIM positions.
module tb_operand_skewer;

  localparam int BW  = 32;
  localparam int DW  = 8;
  localparam int DIM = BW / DW;
  localparam int MW  = DIM * BW;
  localparam int SEQ = 2 * DIM + 1;

  logic          clk = 1'b0;
  logic          rstN;
  logic          startI;
  logic [MW-1:0] matI;
  logic [MW-1:0] laneO;
  logic          readyO;
  logic          busyO;
  logic          doneO;

  int nChecks = 0;
  int nFails  = 0;

  operand_skewer #(
    .BUS_WIDTH (BW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rstN),
    .start_i(startI),
    .mat_i  (matI),
    .lane_o (laneO),
    .ready_o(readyO),
    .busy_o (busyO),
    .done_o (doneO)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  function automatic logic [BW-1:0] wordOf(input logic [MW-1:0] m, input int k);
    return m[k*BW +: BW];
  endfunction

  // Reference model: what lane k should show at position pos of a sequence.
  function automatic logic [BW-1:0] expLane(input logic [MW-1:0] m, input int k, input int pos);
    return (pos == k) ? wordOf(m, k) : '0;
  endfunction

  function automatic logic [MW-1:0] randMat();
    logic [MW-1:0] m;
    for (int k = 0; k < DIM; k++) m[k*BW +: BW] = $urandom;
    return m;
  endfunction

  // Presents a matrix with start for exactly one rising edge, then scrambles
  // mat_i to show later changes are ignored.
  task automatic applyStimulus(input logic [MW-1:0] m);
    @(negedge clk);
    matI   = m;
    startI = 1'b1;
    @(posedge clk);
    #1;
    startI = 1'b0;
    matI   = randMat();
  endtask

  task automatic test_reset();
    rstN   = 1'b0;
    startI = 1'b0;
    matI   = '0;
    repeat (2) @(negedge clk);
    nChecks++;
    if (laneO !== '0 || busyO !== 1'b0 || readyO !== 1'b1 || doneO !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL reset_state: got lane=%h busy=%b ready=%b done=%b want lane=0 busy=0 ready=1 done=0",
               laneO, busyO, readyO, doneO);
    end
    rstN = 1'b1;
    @(negedge clk);
    nChecks++;
    if (readyO !== 1'b1 || busyO !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL reset_release_idle: got busy=%b ready=%b want busy=0 ready=1", busyO, readyO);
    end
  endtask

  // One full sequence checked cycle by cycle against the model. With
  // busyStart set, a second start with another matrix is attempted while
  // the first sequence is running.
  task automatic test_issue(input logic [MW-1:0] m, input string name, input bit busyStart);
    int doneCount;
    logic [MW-1:0] other;
    doneCount = 0;
    other = ~m;
    applyStimulus(m);
    for (int pos = 0; pos < SEQ; pos++) begin
      @(negedge clk);
      for (int k = 0; k < DIM; k++) begin
        nChecks++;
        if (laneO[k*BW +: BW] !== expLane(m, k, pos)) begin
          nFails++;
          $display("[TB] FAIL %s lane%0d pos%0d: got %h want %h",
                   name, k, pos, laneO[k*BW +: BW], expLane(m, k, pos));
        end
      end
      nChecks++;
      if (doneO !== (pos == 2 * DIM - 1)) begin
        nFails++;
        $display("[TB] FAIL %s done pos%0d: got %b want %b", name, pos, doneO, (pos == 2 * DIM - 1));
      end
      nChecks++;
      if (busyO !== (pos < 2 * DIM) || readyO !== (pos >= 2 * DIM)) begin
        nFails++;
        $display("[TB] FAIL %s flags pos%0d: got busy=%b ready=%b want busy=%b ready=%b",
                 name, pos, busyO, readyO, (pos < 2 * DIM), (pos >= 2 * DIM));
      end
      if (doneO === 1'b1) doneCount++;
      if (busyStart && pos == 1) begin
        startI = 1'b1;
        matI   = other;
      end else begin
        startI = 1'b0;
        matI   = randMat();
      end
    end
    nChecks++;
    if (doneCount != 1) begin
      nFails++;
      $display("[TB] FAIL %s done_count: got %0d want 1", name, doneCount);
    end
  endtask

  task automatic test_reset_mid();
    logic [MW-1:0] m;
    m = randMat();
    applyStimulus(m);
    repeat (3) @(posedge clk);
    #2;
    rstN = 1'b0;
    #1;
    nChecks++;
    if (laneO !== '0 || busyO !== 1'b0 || readyO !== 1'b1 || doneO !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL reset_mid_immediate: got lane=%h busy=%b ready=%b done=%b want lane=0 busy=0 ready=1 done=0",
               laneO, busyO, readyO, doneO);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      nChecks++;
      if (doneO !== 1'b0 || laneO !== '0) begin
        nFails++;
        $display("[TB] FAIL reset_mid_hold c%0d: got done=%b lane=%h want done=0 lane=0", c, doneO, laneO);
      end
    end
    rstN = 1'b1;
    for (int c = 0; c < 2 * SEQ; c++) begin
      @(negedge clk);
      nChecks++;
      if (doneO !== 1'b0 || busyO !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL reset_mid_abandoned c%0d: got done=%b busy=%b want done=0 busy=0", c, doneO, busyO);
      end
    end
    test_issue({32'h0D0C0B0A, 32'h09080706, 32'h05040302, 32'h04030201}, "after_reset", 1'b0);
  endtask

  // start_i held high: a new sequence is accepted every SEQ cycles, each one
  // latching whatever mat_i holds on its accepting edge.
  task automatic test_back_to_back();
    logic [MW-1:0] mats [4];
    int doneCount;
    int s;
    int pos;
    doneCount = 0;
    for (int i = 0; i < 4; i++) mats[i] = randMat();
    @(negedge clk);
    matI   = mats[0];
    startI = 1'b1;
    @(posedge clk);
    #1;
    matI = randMat();
    for (int c = 0; c < 3 * SEQ; c++) begin
      @(negedge clk);
      s   = c / SEQ;
      pos = c % SEQ;
      for (int k = 0; k < DIM; k++) begin
        nChecks++;
        if (laneO[k*BW +: BW] !== expLane(mats[s], k, pos)) begin
          nFails++;
          $display("[TB] FAIL b2b seq%0d lane%0d pos%0d: got %h want %h",
                   s, k, pos, laneO[k*BW +: BW], expLane(mats[s], k, pos));
        end
      end
      nChecks++;
      if (doneO !== (pos == 2 * DIM - 1) || readyO !== (pos == 2 * DIM)) begin
        nFails++;
        $display("[TB] FAIL b2b seq%0d pos%0d flags: got done=%b ready=%b want done=%b ready=%b",
                 s, pos, doneO, readyO, (pos == 2 * DIM - 1), (pos == 2 * DIM));
      end
      if (doneO === 1'b1) doneCount++;
      if (pos == 2 * DIM) begin
        matI   = mats[s+1];
        startI = (s < 2);
      end else begin
        matI = randMat();
      end
    end
    startI = 1'b0;
    nChecks++;
    if (doneCount != 3) begin
      nFails++;
      $display("[TB] FAIL b2b_done_count: got %0d want 3", doneCount);
    end
  endtask

  initial begin
    logic [MW-1:0] m;
    test_reset();
    test_issue({32'h0D0C0B0A, 32'h09080706, 32'h05040302, 32'h04030201}, "basic", 1'b0);
    for (int i = 0; i < 3; i++) begin
      m = randMat();
      test_issue(m, "random", 1'b0);
    end
    test_issue(randMat(), "start_busy", 1'b1);
    m = randMat();
    m[1*BW +: BW] = '0;
    test_issue(m, "zero_row", 1'b0);
    test_issue('0, "zero_matrix", 1'b0);
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
